// File: rtl/bcd_count_scan_if.sv
// Bundle of the counter controls and the scanned display outputs of bcd_count_scan.
// The master side drives CLR/INC/DEC; the slave side (the counter) drives NUM/AN/CARRY/BORROW.
interface bcd_count_scan_if;
    logic       CLR;
    logic       INC;
    logic       DEC;
    logic [3:0] NUM;
    logic [3:0] AN;
    logic       CARRY;
    logic       BORROW;

    modport master (
        output CLR, INC, DEC,
        input  NUM, AN, CARRY, BORROW
    );

    modport slave (
        input  CLR, INC, DEC,
        output NUM, AN, CARRY, BORROW
    );
endinterface

// File: rtl/bcd_count_scan.sv
// 4-digit BCD up/down counter (0000-9999) with a time-multiplexed digit scanner.
// Optional macro LEADING_ZERO_BLANK_EN: show leading zero digits (except digit 0) as 4'hF.
module bcd_count_scan #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic              CLK,
    input  logic              RST,
    bcd_count_scan_if.slave   bus
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [3:0][3:0] cnt_q, cnt_d;
    logic            carry_q, carry_d;
    logic            borrow_q, borrow_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      an_q, an_d;
    logic [3:0]      num_q, num_d;
    logic            rip;

    // Ripple stops at the first nibble that does not wrap; a ripple out of D3 is the wrap pulse.
    always_comb begin
        cnt_d    = cnt_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        rip      = 1'b1;
        if (bus.CLR) begin
            cnt_d = '0;
        end else if (bus.INC && !bus.DEC) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (rip) begin
                    if (cnt_q[i] == 4'd9) begin
                        cnt_d[i] = 4'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                        rip      = 1'b0;
                    end
                end
            end
            carry_d = rip;
        end else if (bus.DEC && !bus.INC) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (rip) begin
                    if (cnt_q[i] == 4'd0) begin
                        cnt_d[i] = 4'd9;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 4'd1;
                        rip      = 1'b0;
                    end
                end
            end
            borrow_d = rip;
        end
    end

    // AN and NUM are both derived from the next scan index so they update on the same edge.
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
        an_d  = ~(4'b0001 << idx_d);
        num_d = cnt_q[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd3:    if (cnt_q[3] == 4'd0) num_d = 4'hF;
            2'd2:    if (cnt_q[3] == 4'd0 && cnt_q[2] == 4'd0) num_d = 4'hF;
            2'd1:    if (cnt_q[3] == 4'd0 && cnt_q[2] == 4'd0 && cnt_q[1] == 4'd0) num_d = 4'hF;
            default: num_d = cnt_q[0];
        endcase
`endif
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            presc_q  <= '0;
            idx_q    <= '0;
            an_q     <= 4'b1110;
            num_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            an_q     <= an_d;
            num_q    <= num_d;
        end
    end

    assign bus.NUM    = num_q;
    assign bus.AN     = an_q;
    assign bus.CARRY  = carry_q;
    assign bus.BORROW = borrow_q;

endmodule

// File: tb/tb_bcd_count_scan.sv
// Directed, table-driven bench for bcd_count_scan with SCAN_DIV=4.
module tb_bcd_count_scan;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    bcd_count_scan_if bus ();

    bcd_count_scan #(.SCAN_DIV(4)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic        inc;
        logic        dec;
        logic [15:0] cnt;
        logic        carry;
        logic        borrow;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic inc_n(input int n);
        bus.INC = 1'b1;
        repeat (n) step();
        bus.INC = 1'b0;
    endtask

    // Collect the digit shown under each AN position over one full scan rotation.
    task automatic scan_read(output logic [15:0] v, output bit ok);
        logic [3:0] seen;
        seen = '0;
        v    = '0;
        for (int i = 0; i < 40 && seen != 4'hF; i++) begin
            step();
            case (bus.AN)
                4'b1110: begin v[3:0]   = bus.NUM; seen[0] = 1'b1; end
                4'b1101: begin v[7:4]   = bus.NUM; seen[1] = 1'b1; end
                4'b1011: begin v[11:8]  = bus.NUM; seen[2] = 1'b1; end
                4'b0111: begin v[15:12] = bus.NUM; seen[3] = 1'b1; end
                default: ;
            endcase
        end
        ok = (seen == 4'hF);
    endtask

    task automatic wait_an(input logic [3:0] an, input string name);
        int n;
        n = 0;
        while (bus.AN !== an && n < 20) begin
            step();
            n++;
        end
        if (bus.AN !== an) timeout(name);
    endtask

    task automatic scan_check(input string name, input logic [15:0] exp);
        logic [15:0] v;
        bit ok;
        scan_read(v, ok);
        if (!ok) timeout(name);
        else check(name, v, exp);
    endtask

    initial begin
        logic [15:0] v;
        bit ok;
        int idx;

        bus.CLR = 1'b0;
        bus.INC = 1'b1;
        bus.DEC = 1'b0;

        // Reset held 3 cycles with INC high.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        bus.INC = 1'b0;
        check("rst_cnt", dut.cnt_q, 16'h0000);
        check("rst_an", {12'h0, bus.AN}, 16'h000E);
        check("rst_num", {12'h0, bus.NUM}, 16'h0000);
        check("rst_pulses", {14'h0, bus.CARRY, bus.BORROW}, 16'h0000);
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("rst_an_c%0d", c), {12'h0, bus.AN},
                  (c == 4) ? 16'h000D : 16'h000E);
        end

        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h9998, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            bus.CLR = vecs[i].clr;
            bus.INC = vecs[i].inc;
            bus.DEC = vecs[i].dec;
            step();
            check($sformatf("vec%0d_cnt", i), dut.cnt_q, vecs[i].cnt);
            check($sformatf("vec%0d_pulse", i), {14'h0, bus.CARRY, bus.BORROW},
                  {14'h0, vecs[i].carry, vecs[i].borrow});
        end
        bus.CLR = 1'b0;
        bus.INC = 1'b0;
        bus.DEC = 1'b0;
        step();
        check("carry_one_cycle", {14'h0, bus.CARRY, bus.BORROW}, 16'h0000);

        // Ten INCs ripple into D1.
        inc_n(10);
        check("roll10_cnt", dut.cnt_q, 16'h0010);
        scan_read(v, ok);
        if (!ok) timeout("roll10_scan");
        else begin
            check("roll10_d1", {12'h0, v[7:4]}, 16'h0001);
            check("roll10_d0", {12'h0, v[3:0]}, 16'h0000);
        end

        // Simultaneous requests at 0457.
        bus.CLR = 1'b1;
        step();
        bus.CLR = 1'b0;
        inc_n(457);
        check("pre457", dut.cnt_q, 16'h0457);
        bus.INC = 1'b1;
        bus.DEC = 1'b1;
        step();
        check("incdec_cnt", dut.cnt_q, 16'h0457);
        check("incdec_pulse", {14'h0, bus.CARRY, bus.BORROW}, 16'h0000);
        bus.DEC = 1'b0;
        bus.CLR = 1'b1;
        step();
        bus.CLR = 1'b0;
        bus.INC = 1'b0;
        check("clrinc_cnt", dut.cnt_q, 16'h0000);

        // Reset in the middle of a scan.
        inc_n(321);
        check("pre321", dut.cnt_q, 16'h0321);
        wait_an(4'b1011, "midrst_wait");
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_an", {12'h0, bus.AN}, 16'h000E);
        check("midrst_num", {12'h0, bus.NUM}, 16'h0000);
        check("midrst_cnt", dut.cnt_q, 16'h0000);

        // Free-running scan of 1234.
        inc_n(1234);
        wait_an(4'b0111, "scan_sync3");
        wait_an(4'b1110, "scan_sync0");
        v = 16'h1234;
        for (int c = 1; c <= 32; c++) begin
            step();
            idx = (c / 4) % 4;
            check($sformatf("scan_an_c%0d", c), {12'h0, bus.AN},
                  {12'h0, ~(4'b0001 << idx)});
            check($sformatf("scan_num_c%0d", c), {12'h0, bus.NUM}, {12'h0, v[idx*4 +: 4]});
        end

        // Leading-zero handling.
        rst = 1'b1;
        step();
        rst = 1'b0;
        scan_check("zero_scan", 16'h0000 `ifdef LEADING_ZERO_BLANK_EN | 16'hFFF0 `endif);
        inc_n(42);
`ifdef LEADING_ZERO_BLANK_EN
        scan_check("lzb_0042", 16'hFF42);
`else
        scan_check("raw_0042", 16'h0042);
`endif
        bus.CLR = 1'b1;
        step();
        bus.CLR = 1'b0;
        inc_n(1002);
        scan_check("scan_1002", 16'h1002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
